// File: rtl/trigger_frame_writer_if.sv
// Bundle of the RFDC input stream, trigger level and the two FIFO write ports.
// The master modport is the frame writer itself; slave is its environment.
interface trigger_frame_writer_if;
  logic                S_AXIS_TVALID;
  logic [127:0]        S_AXIS_TDATA;
  logic signed [15:0]  THRESHOLD;
  logic                ADC_FIFO_FULL;
  logic                ADC_FIFO_WR_EN;
  logic [127:0]        ADC_FIFO_DIN;
  logic                HF_FIFO_FULL;
  logic                HF_FIFO_WR_EN;
  logic [191:0]        HF_FIFO_DIN;
  logic                TRIGGER_ERROR;

  modport master (
    input  S_AXIS_TVALID, S_AXIS_TDATA, THRESHOLD, ADC_FIFO_FULL, HF_FIFO_FULL,
    output ADC_FIFO_WR_EN, ADC_FIFO_DIN, HF_FIFO_WR_EN, HF_FIFO_DIN, TRIGGER_ERROR
  );

  modport slave (
    output S_AXIS_TVALID, S_AXIS_TDATA, THRESHOLD, ADC_FIFO_FULL, HF_FIFO_FULL,
    input  ADC_FIFO_WR_EN, ADC_FIFO_DIN, HF_FIFO_WR_EN, HF_FIFO_DIN, TRIGGER_ERROR
  );
endinterface

// File: rtl/trigger_frame_writer.sv
// Threshold-triggered frame capture of one RFDC channel into an ADC-word FIFO
// and a header/footer FIFO, with pre-/post-trigger windows and a length cap.
module trigger_frame_writer #(
  parameter logic [7:0] CH_ID         = 8'h00,
  parameter int         PRE_ACQ_LEN   = 2,
  parameter int         POST_ACQ_LEN  = 2,
  parameter int         MAX_FRAME_LEN = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  trigger_frame_writer_if.master bus
);

  localparam int DATA_W = 128;
  localparam int HF_W   = 192;
  localparam int NSAMP  = 8;
  localparam int LEN_W  = 12;
  localparam int TS_W   = 48;
  localparam int FC_W   = 32;
  localparam int PC_W   = 4;

  typedef enum logic [2:0] {IDLE, ACQUIRE, POST, CLOSE, ERROR} state_t;

  function automatic logic any_above(input logic [DATA_W-1:0] w,
                                     input logic signed [15:0] thr);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NSAMP; i++) begin
      if ($signed(w[16*i +: 16]) > thr) r = 1'b1;
    end
    return r;
  endfunction

  logic              vld_p0_q;
  logic [DATA_W-1:0] data_p0_q;
  logic [DATA_W-1:0] dl_q [PRE_ACQ_LEN];
  logic              arm_q;
  logic [TS_W-1:0]   ts_q;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               trunc_q, trunc_d;
  logic [TS_W-1:0]    ts_lat_q, ts_lat_d;
  logic signed [15:0] thr_lat_q, thr_lat_d;
  logic [FC_W-1:0]    fcnt_q, fcnt_d;
  logic               adc_wr_q, adc_wr_d;
  logic [DATA_W-1:0]  adc_din_q, adc_din_d;
  logic               hf_wr_q, hf_wr_d;
  logic [HF_W-1:0]    hf_din_q, hf_din_d;
  logic               err_q, err_d;

  logic              hit_w;
  logic              write_w;
  logic [DATA_W-1:0] tail_w;

  assign hit_w  = any_above(data_p0_q, bus.THRESHOLD);
  assign tail_w = dl_q[PRE_ACQ_LEN-1];

  // Stage p0 -> trigger decision; every write slot is a valid p0 cycle
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pc_d      = pc_q;
    trunc_d   = trunc_q;
    ts_lat_d  = ts_lat_q;
    thr_lat_d = thr_lat_q;
    fcnt_d    = fcnt_q;
    adc_wr_d  = 1'b0;
    adc_din_d = adc_din_q;
    hf_wr_d   = 1'b0;
    hf_din_d  = hf_din_q;
    err_d     = err_q;
    write_w   = 1'b0;

    case (state_q)
      IDLE: begin
        if (vld_p0_q && arm_q && hit_w) begin
          write_w   = 1'b1;
          ts_lat_d  = ts_q;
          thr_lat_d = bus.THRESHOLD;
          trunc_d   = 1'b0;
          state_d   = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (vld_p0_q) begin
          if (hit_w) begin
            write_w = 1'b1;
          end else if (POST_ACQ_LEN == 0) begin
            state_d = CLOSE;
          end else begin
            write_w = 1'b1;
            pc_d    = PC_W'(POST_ACQ_LEN);
            state_d = POST;
          end
        end
      end
      POST: begin
        if (vld_p0_q) begin
          write_w = 1'b1;
          if (hit_w)              state_d = ACQUIRE;
          else if (pc_q == '0)    state_d = CLOSE;
          else                    pc_d    = pc_q - 1'b1;
        end
      end
      CLOSE: begin
        if (bus.HF_FIFO_FULL) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else begin
          hf_wr_d  = 1'b1;
          hf_din_d = {8'hAA, CH_ID, len_q, 36'd0, ts_lat_q, thr_lat_q,
                      8'h55, 7'd0, trunc_q, fcnt_q, 16'd0};
          fcnt_d   = fcnt_q + 1'b1;
          state_d  = IDLE;
        end
      end
      ERROR: err_d = 1'b1;
      default: state_d = IDLE;
    endcase

    // A full ADC FIFO on a due write kills the frame without a partial write
    if (write_w) begin
      if (bus.ADC_FIFO_FULL) begin
        err_d   = 1'b1;
        state_d = ERROR;
      end else begin
        adc_wr_d  = 1'b1;
        adc_din_d = tail_w;
        len_d     = (state_q == IDLE) ? LEN_W'(1) : len_q + 1'b1;
        if (len_d == LEN_W'(MAX_FRAME_LEN)) begin
          trunc_d = 1'b1;
          state_d = CLOSE;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      vld_p0_q  <= 1'b0;
      data_p0_q <= '0;
      for (int i = 0; i < PRE_ACQ_LEN; i++) dl_q[i] <= '0;
      arm_q     <= 1'b0;
      ts_q      <= '0;
      state_q   <= IDLE;
      len_q     <= '0;
      pc_q      <= '0;
      trunc_q   <= 1'b0;
      ts_lat_q  <= '0;
      thr_lat_q <= '0;
      fcnt_q    <= '0;
      adc_wr_q  <= 1'b0;
      adc_din_q <= '0;
      hf_wr_q   <= 1'b0;
      hf_din_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      vld_p0_q  <= bus.S_AXIS_TVALID;
      data_p0_q <= bus.S_AXIS_TDATA;
      // Delay line and word counters advance only on valid words
      if (vld_p0_q) begin
        dl_q[0] <= data_p0_q;
        for (int i = 1; i < PRE_ACQ_LEN; i++) dl_q[i] <= dl_q[i-1];
        ts_q <= ts_q + TS_W'(1);
        if (ts_q >= TS_W'(PRE_ACQ_LEN - 1)) arm_q <= 1'b1;
      end
      state_q   <= state_d;
      len_q     <= len_d;
      pc_q      <= pc_d;
      trunc_q   <= trunc_d;
      ts_lat_q  <= ts_lat_d;
      thr_lat_q <= thr_lat_d;
      fcnt_q    <= fcnt_d;
      adc_wr_q  <= adc_wr_d;
      adc_din_q <= adc_din_d;
      hf_wr_q   <= hf_wr_d;
      hf_din_q  <= hf_din_d;
      err_q     <= err_d;
    end
  end

  assign bus.ADC_FIFO_WR_EN = adc_wr_q;
  assign bus.ADC_FIFO_DIN   = adc_din_q;
  assign bus.HF_FIFO_WR_EN  = hf_wr_q;
  assign bus.HF_FIFO_DIN    = hf_din_q;
  assign bus.TRIGGER_ERROR  = err_q;

endmodule

// File: tb/tb_trigger_frame_writer.sv
// Bench for trigger_frame_writer: two instances (cap 256 and cap 4) share one
// stimulus stream and are compared cycle by cycle against a window-rule model.
module tb_trigger_frame_writer;
  localparam int PRE  = 2;
  localparam int POST = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  trigger_frame_writer_if bus_a ();
  trigger_frame_writer_if bus_b ();

  trigger_frame_writer #(.CH_ID(8'h03), .PRE_ACQ_LEN(PRE), .POST_ACQ_LEN(POST),
                         .MAX_FRAME_LEN(256)) dut_a (.ACLK(clk), .ARESET(rst), .bus(bus_a));
  trigger_frame_writer #(.CH_ID(8'h03), .PRE_ACQ_LEN(PRE), .POST_ACQ_LEN(POST),
                         .MAX_FRAME_LEN(4)) dut_b (.ACLK(clk), .ARESET(rst), .bus(bus_b));

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [127:0] d;} adc_t;
  typedef struct {int cyc; logic [191:0] v;} hf_t;

  int n_err = 0;
  int n_chk = 0;

  logic               st_vld[$];
  logic [127:0]       st_data[$];
  logic               st_af[$];
  logic               st_hf[$];
  logic signed [15:0] thr;

  adc_t m_adc[$], exp_adc_a[$], exp_adc_b[$];
  hf_t  m_hf[$],  exp_hf_a[$],  exp_hf_b[$];
  int   m_err, err_a, err_b;
  int   obs_adc_a, obs_hf_a, obs_adc_b, obs_hf_b;
  logic [191:0] first_hf_a, first_hf_b;

  function automatic logic [127:0] bg_word();
    logic [127:0] w;
    int s;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      s = int'(thr) - int'($urandom_range(0, 3000));
      if (s < -32768) s = -32768;
      w[16*i +: 16] = s[15:0];
    end
    return w;
  endfunction

  function automatic logic [127:0] lane_word(input int lane, input int val);
    logic [127:0] w;
    logic [31:0]  v;
    w = bg_word();
    v = val;
    w[16*lane +: 16] = v[15:0];
    return w;
  endfunction

  function automatic logic [127:0] hit_word();
    int s;
    s = int'(thr) + 1 + int'($urandom_range(0, 3000));
    if (s > 32767) s = 32767;
    return lane_word(int'($urandom_range(0, 7)), s);
  endfunction

  function automatic bit is_hit(input logic [127:0] w, input logic signed [15:0] t);
    logic signed [15:0] s;
    for (int i = 0; i < 8; i++) begin
      s = w[16*i +: 16];
      if (s > t) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [191:0] hf_word(input int len, input int ts,
                                           input logic signed [15:0] t, input bit tr,
                                           input logic [31:0] fc);
    return {8'hAA, 8'h03, 12'(len), 36'd0, 48'(ts), t, 8'h55, 7'd0, tr, fc, 16'd0};
  endfunction

  task automatic add(input logic v, input logic [127:0] d,
                     input logic af = 1'b0, input logic hf = 1'b0);
    st_vld.push_back(v);
    st_data.push_back(d);
    st_af.push_back(af);
    st_hf.push_back(hf);
  endtask

  // A frame spans tail words trigger-PRE .. last_hit+POST; each write appears one
  // cycle after its word's slot, the header one cycle after the last write.
  task automatic build_model(input int maxlen);
    logic [127:0] words[$];
    bit open, err, h;
    int len, endn, ts, dead, n, N;
    logic [31:0] fc;
    logic signed [15:0] tcap;
    m_adc.delete(); m_hf.delete();
    m_err = -1; open = 0; err = 0; dead = -1; fc = 0;
    len = 0; endn = 0; ts = 0; tcap = 0;
    N = st_vld.size();
    for (int c = 0; c < N; c++) begin
      if (!st_vld[c]) continue;
      words.push_back(st_data[c]);
      n = words.size() - 1;
      if (err || c == dead) continue;
      h = is_hit(st_data[c], thr);
      if (!open) begin
        if (!(n >= PRE && h)) continue;
        open = 1; len = 0; ts = n; tcap = thr; endn = n + POST + PRE;
      end else if (h) begin
        endn = n + POST + PRE;
      end
      if (c + 1 < N && st_af[c+1]) begin
        err = 1; m_err = c + 1;
        continue;
      end
      m_adc.push_back('{c + 1, words[n-PRE]});
      len++;
      if (len == maxlen || n == endn) begin
        open = 0; dead = c + 1;
        if (c + 2 < N && st_hf[c+2]) begin
          err = 1; m_err = c + 2;
        end else begin
          m_hf.push_back('{c + 2, hf_word(len, ts, tcap, len == maxlen, fc)});
          fc++;
        end
      end
    end
  endtask

  task automatic drive(input int c);
    bus_a.S_AXIS_TVALID = st_vld[c];  bus_b.S_AXIS_TVALID = st_vld[c];
    bus_a.S_AXIS_TDATA  = st_data[c]; bus_b.S_AXIS_TDATA  = st_data[c];
    bus_a.ADC_FIFO_FULL = st_af[c];   bus_b.ADC_FIFO_FULL = st_af[c];
    bus_a.HF_FIFO_FULL  = st_hf[c];   bus_b.HF_FIFO_FULL  = st_hf[c];
    bus_a.THRESHOLD     = thr;        bus_b.THRESHOLD     = thr;
  endtask

  task automatic drive_idle();
    bus_a.S_AXIS_TVALID = 1'b0; bus_b.S_AXIS_TVALID = 1'b0;
    bus_a.S_AXIS_TDATA  = '0;   bus_b.S_AXIS_TDATA  = '0;
    bus_a.ADC_FIFO_FULL = 1'b0; bus_b.ADC_FIFO_FULL = 1'b0;
    bus_a.HF_FIFO_FULL  = 1'b0; bus_b.HF_FIFO_FULL  = 1'b0;
    bus_a.THRESHOLD     = thr;  bus_b.THRESHOLD     = thr;
  endtask

  task automatic chk_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_pair(input string tag, input int c, input logic got_s,
                          input logic [191:0] got_v, input logic exp_s,
                          input logic [191:0] exp_v);
    n_chk++;
    assert (got_s === exp_s) else begin
      n_err++;
      $error("FAIL %s_strobe cyc=%0d observed=%b expected=%b", tag, c, got_s, exp_s);
    end
    if (exp_s) begin
      n_chk++;
      assert (got_v === exp_v) else begin
        n_err++;
        $error("FAIL %s_data cyc=%0d observed=%h expected=%h", tag, c, got_v, exp_v);
      end
    end
  endtask

  task automatic check_reset();
    chk_val("reset_a", {63'd0, bus_a.ADC_FIFO_WR_EN, bus_a.ADC_FIFO_DIN},   '0);
    chk_val("reset_a_hf", {bus_a.HF_FIFO_DIN},                               '0);
    chk_val("reset_a_flags", {190'd0, bus_a.HF_FIFO_WR_EN, bus_a.TRIGGER_ERROR}, '0);
    chk_val("reset_b", {63'd0, bus_b.ADC_FIFO_WR_EN, bus_b.ADC_FIFO_DIN},   '0);
    chk_val("reset_b_flags", {190'd0, bus_b.HF_FIFO_WR_EN, bus_b.TRIGGER_ERROR}, '0);
  endtask

  task automatic check_cycle(input int c);
    logic e;
    e = exp_adc_a.size() > 0 && exp_adc_a[0].cyc == c;
    chk_pair("a_adc", c, bus_a.ADC_FIFO_WR_EN, {64'd0, bus_a.ADC_FIFO_DIN},
             e, e ? {64'd0, exp_adc_a[0].d} : 192'd0);
    if (e) void'(exp_adc_a.pop_front());
    if (bus_a.ADC_FIFO_WR_EN) obs_adc_a++;
    e = exp_hf_a.size() > 0 && exp_hf_a[0].cyc == c;
    chk_pair("a_hf", c, bus_a.HF_FIFO_WR_EN, bus_a.HF_FIFO_DIN, e, e ? exp_hf_a[0].v : 192'd0);
    if (e) void'(exp_hf_a.pop_front());
    if (bus_a.HF_FIFO_WR_EN && obs_hf_a == 0) first_hf_a = bus_a.HF_FIFO_DIN;
    if (bus_a.HF_FIFO_WR_EN) obs_hf_a++;
    chk_pair("a_err", c, bus_a.TRIGGER_ERROR, '0, err_a >= 0 && c >= err_a, '0);

    e = exp_adc_b.size() > 0 && exp_adc_b[0].cyc == c;
    chk_pair("b_adc", c, bus_b.ADC_FIFO_WR_EN, {64'd0, bus_b.ADC_FIFO_DIN},
             e, e ? {64'd0, exp_adc_b[0].d} : 192'd0);
    if (e) void'(exp_adc_b.pop_front());
    if (bus_b.ADC_FIFO_WR_EN) obs_adc_b++;
    e = exp_hf_b.size() > 0 && exp_hf_b[0].cyc == c;
    chk_pair("b_hf", c, bus_b.HF_FIFO_WR_EN, bus_b.HF_FIFO_DIN, e, e ? exp_hf_b[0].v : 192'd0);
    if (e) void'(exp_hf_b.pop_front());
    if (bus_b.HF_FIFO_WR_EN && obs_hf_b == 0) first_hf_b = bus_b.HF_FIFO_DIN;
    if (bus_b.HF_FIFO_WR_EN) obs_hf_b++;
    chk_pair("b_err", c, bus_b.TRIGGER_ERROR, '0, err_b >= 0 && c >= err_b, '0);
  endtask

  task automatic run();
    for (int i = 0; i < 12; i++) add(1'b0, '0);
    build_model(256);
    exp_adc_a = m_adc; exp_hf_a = m_hf; err_a = m_err;
    build_model(4);
    exp_adc_b = m_adc; exp_hf_b = m_hf; err_b = m_err;
    obs_adc_a = 0; obs_hf_a = 0; obs_adc_b = 0; obs_hf_b = 0;
    first_hf_a = '0; first_hf_b = '0;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    for (int c = 0; c < st_vld.size(); c++) begin
      drive(c);
      @(posedge clk);
      #1;
      check_cycle(c);
    end
    chk_val("leftover_expected", 192'(exp_adc_a.size() + exp_hf_a.size()
                                      + exp_adc_b.size() + exp_hf_b.size()), '0);
    st_vld.delete(); st_data.delete(); st_af.delete(); st_hf.delete();
  endtask

  initial begin
    thr = 16'sd100;
    drive_idle();

    // Single hit, sample value 101
    for (int n = 0; n < 30; n++) add(1'b1, n == 10 ? lane_word(int'($urandom_range(0, 7)), 101) : bg_word());
    run();
    chk_val("single_writes", 192'(obs_adc_a), 192'd5);
    chk_val("single_len",   192'(first_hf_a[175:164]), 192'd5);
    chk_val("single_ts",    192'(first_hf_a[127:80]), 192'd10);
    chk_val("single_cnt_flags", 192'({first_hf_a[55:48], first_hf_a[47:16]}), 192'd0);

    // Retrigger
    for (int n = 0; n < 30; n++) add(1'b1, (n == 10 || n == 12) ? hit_word() : bg_word());
    run();
    chk_val("retrig_writes", 192'(obs_adc_a), 192'd7);
    chk_val("retrig_hf",     192'(obs_hf_a), 192'd1);
    chk_val("retrig_len",    192'(first_hf_a[175:164]), 192'd7);

    // Truncation with back-to-back frames on the cap-4 instance
    for (int n = 0; n < 40; n++) add(1'b1, (n >= 10 && n <= 20) ? hit_word() : bg_word());
    run();
    chk_val("trunc_len",    192'(first_hf_b[175:164]), 192'd4);
    chk_val("trunc_flag",   192'(first_hf_b[55:48]), 192'd1);
    chk_val("trunc_frames", 192'(obs_hf_b), 192'd3);
    chk_val("trunc_writes", 192'(obs_adc_b), 192'd12);

    // Gapped TVALID 1010...
    for (int c = 0; c < 60; c++) add(c % 2 == 0, (c % 2 == 0 && c / 2 == 10) ? hit_word() : bg_word());
    run();
    chk_val("gap_writes", 192'(obs_adc_a), 192'd5);
    chk_val("gap_ts",     192'(first_hf_a[127:80]), 192'd10);

    // Threshold boundary: equal is not above
    for (int n = 0; n < 30; n++) add(1'b1, n == 10 ? lane_word(int'($urandom_range(0, 7)), 100) : bg_word());
    run();
    chk_val("equal_thr_writes", 192'(obs_adc_a + obs_adc_b), 192'd0);
    thr = -16'sd32768;
    for (int n = 0; n < 30; n++) add(1'b1, bg_word());
    run();
    chk_val("min_thr_writes", 192'(obs_adc_a + obs_adc_b), 192'd0);

    // Random stream
    thr = 16'(int'($urandom_range(0, 400)) - 200);
    for (int c = 0; c < 300; c++) add($urandom_range(0, 9) < 8, $urandom_range(0, 24) == 0 ? hit_word() : bg_word());
    run();

    // ADC FIFO overflow mid-frame
    thr = 16'sd100;
    for (int n = 0; n < 40; n++) add(1'b1, (n == 10 || n == 25) ? hit_word() : bg_word(), n >= 13 && n <= 16);
    run();
    chk_val("ovf_writes", 192'(obs_adc_a), 192'd2);
    chk_val("ovf_hf",     192'(obs_hf_a), 192'd0);
    chk_val("ovf_sticky", 192'(bus_a.TRIGGER_ERROR), 192'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;

    // HF FIFO full at close
    for (int n = 0; n < 30; n++) add(1'b1, n == 10 ? hit_word() : bg_word(), 1'b0, 1'b1);
    run();
    chk_val("hffull_writes", 192'(obs_adc_a), 192'd5);
    chk_val("hffull_hf",     192'(obs_hf_a), 192'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/trigger_frame_writer.md
# trigger_frame_writer

Upstream stage of the dataframe generator. Watches the RFDC ADC stream for one channel, applies a per-word threshold trigger with pre-/post-acquisition windows, and writes each triggered frame into two FIFOs. ADC words go to the ADC FIFO. One header/footer word per frame goes to the HF FIFO and carries the frame length, the timestamp and the frame count. The dataframe generator drains both FIFOs to build AXIS frames.

## Interface
Parameters:
- CH_ID, 8'h00: channel ID placed in the header.
- PRE_ACQ_LEN, 2: ADC words written before the trigger word (1..15).
- POST_ACQ_LEN, 2: ADC words written after the last above-threshold word (0..15).
- MAX_FRAME_LEN, 256: maximum ADC words per frame (1..4095).

Widths come from dataframe_config.vh: RFDC_TDATA_WIDTH=128, DATAFRAME_WIDTH=64, HEADER_LINE=2, FOOTER_LINE=1.

Ports:
- ACLK, in, 1: clock. One clock domain only.
- ARESET, in, 1: reset. Synchronous and active-high.
- S_AXIS_TVALID, in, 1: RFDC word valid. There is no TREADY; the block must never stall the RFDC.
- S_AXIS_TDATA, in, 128: 8 signed 16-bit samples. Sample i sits at [16i+15:16i].
- THRESHOLD, in, 16: signed trigger level. Held quasi-static by software.
- ADC_FIFO_FULL, in, 1: ADC FIFO full flag.
- ADC_FIFO_WR_EN, out, 1: ADC FIFO write strobe.
- ADC_FIFO_DIN, out, 128: ADC word to write.
- HF_FIFO_FULL, in, 1: HF FIFO full flag.
- HF_FIFO_WR_EN, out, 1: HF FIFO write strobe.
- HF_FIFO_DIN, out, 192: header/footer word to write.
- TRIGGER_ERROR, out, 1: sticky overflow flag.

## Operation
- Input stage s0 registers TDATA and TVALID.
- A delay line of PRE_ACQ_LEN stages follows s0. It shifts only on cycles where s0 is valid.
- Word count: one "word" = one s0-valid cycle.
- `hit` = any of the 8 samples in s0 is strictly greater than THRESHOLD (signed compare).
- Arming: the trigger is disabled until PRE_ACQ_LEN+1 valid words have been received since reset.
- A write slot is an s0-valid cycle. ADC_FIFO_DIN is the delay-line tail, i.e. the word received PRE_ACQ_LEN words before s0.
- 48-bit timestamp counter: cleared at reset, incremented on every valid word. A frame's timestamp is the counter value captured on the trigger slot.
- 32-bit frame counter: cleared at reset, incremented after each HF write. Wraps modulo 2^32.
- State machine (states IDLE, ACQUIRE, POST, CLOSE, ERROR):
  - IDLE: on an armed hit, write the tail and go to ACQUIRE. Length = 1; latch the timestamp.
  - ACQUIRE: write the tail in every slot. A hit stays in ACQUIRE. A non-hit goes to POST with postcnt = POST_ACQ_LEN. If POST_ACQ_LEN = 0, a non-hit writes nothing more and goes to CLOSE.
  - POST: write in every slot and decrement postcnt. A hit returns to ACQUIRE (retrigger). When postcnt reaches 0 after the write, go to CLOSE.
  - Length cap, any writing state: the write that brings length to MAX_FRAME_LEN is the last one. Set the truncated flag and go to CLOSE.
  - CLOSE: one cycle. Assert HF_FIFO_WR_EN, then go to IDLE. Words arriving in this cycle shift through but are neither written nor trigger-evaluated (one-word dead time).
  - ERROR: entered from any writing state when a write is due and ADC_FIFO_FULL=1. Also entered from CLOSE when HF_FIFO_FULL=1. The due write is suppressed. No further writes until ARESET. TRIGGER_ERROR=1.
- HF_FIFO_DIN layout:
  - [191:184] = 8'hAA (header ID).
  - [183:176] = CH_ID.
  - [175:164] = frame length in 128-bit words.
  - [163:128] = 0.
  - [127:80] = timestamp.
  - [79:64] = THRESHOLD captured at trigger.
  - [63:56] = 8'h55 (footer ID).
  - [55:48] = flags; bit0 = truncated, other bits 0.
  - [47:16] = frame count.
  - [15:0] = 0.

## Timing
- Reset values: ADC_FIFO_WR_EN=0, HF_FIFO_WR_EN=0, ADC_FIFO_DIN=0, HF_FIFO_DIN=0, TRIGGER_ERROR=0. State IDLE. All counters 0. Delay line zeroed and disarmed.
- All outputs are registered.
- Latency: a word accepted on S_AXIS at edge k is in s0 after edge k. If it is the trigger word, ADC_FIFO_WR_EN rises after edge k+1, carrying the word from PRE_ACQ_LEN valid words earlier.
- HF_FIFO_WR_EN pulses exactly one cycle, the cycle after the frame's last ADC write. At that point every ADC word of the frame is already written.
- A TVALID gap creates no write and does not advance postcnt, length or the timestamp.
- ARESET mid-frame aborts the frame immediately, with no HF write. Downstream is reset together with this block.
- Simultaneous full flag and due write: the error wins and no partial write happens.

## Test plan
- Setup for all scenarios: PRE=2, POST=2, MAX=256, THRESHOLD=100, continuous TVALID, CH_ID=3.
- Single hit: sample = 101 in word 10 only -> 5 ADC writes (words 8..12); HF: len=5, timestamp=10, count=0, flags=0.
- Retrigger: hits in words 10 and 12 -> 7 writes (words 8..14), a single HF write with len=7.
- Truncation: MAX=4, hits in words 10..20 -> 4 writes; HF flags bit0=1, len=4; back-to-back frame behaviour obeys the one-word dead time.
- Gapped TVALID: TVALID toggles 1010…, single hit -> 5 writes spaced 2 cycles apart; postcnt advances only on valid words.
- Threshold boundary: sample = 100 -> no trigger; sample = -32768 with THRESHOLD = -32768 -> no trigger (strict compare).
- Overflow: ADC_FIFO_FULL=1 during a frame -> TRIGGER_ERROR=1 on the next cycle, no HF write, no further writes until ARESET; after ARESET all outputs return to 0.
